djb2_verify: RTL and testbench

DJB2_VERIFY -- requirements
Module: djb2_verify

---
 rtl/djb2_pkg.sv | 13 +
 rtl/djb2_step.sv | 20 ++
 rtl/djb2_verify.sv | 112 +++++++++++
 tb/tb_djb2_verify.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/djb2_pkg.sv
// Shared constants and FSM state type for the djb2 message verifier.
package djb2_pkg;

  localparam logic [31:0] DJB2_SEED = 32'd5381;
  localparam logic [31:0] DJB2_MULT = 32'd33;

  typedef enum logic [1:0] {
    IDLE,
    HASH,
    DONE
  } state_t;

endpackage

// File: rtl/djb2_step.sv
// One djb2 per-byte update: additive by default, djb2a (XOR) when DJB2_XOR_EN is defined.
module djb2_step
  import djb2_pkg::*;
(
  input  logic [31:0] hash_in,
  input  logic [7:0]  byte_in,
  output logic [31:0] hash_out
);

  logic [31:0] scaled;

  assign scaled = hash_in * DJB2_MULT;

`ifdef DJB2_XOR_EN
  assign hash_out = scaled ^ {24'd0, byte_in};
`else
  assign hash_out = scaled + {24'd0, byte_in};
`endif

endmodule

// File: rtl/djb2_verify.sv
// Streams a message through djb2 and compares the digest with a latched expected value.
// Optional djb2a variant selected by macro DJB2_XOR_EN (see djb2_step).
module djb2_verify
  import djb2_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      exp_hash,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [31:0]      hash_out,
  output logic [LEN_W-1:0] len_out,
  output logic             err
);

  state_t             state;
  logic [31:0]        hash_acc;
  logic [31:0]        exp_lat;
  logic [LEN_W-1:0]   len_cnt;
  logic               err_acc;

  logic               accept;
  logic [31:0]        hash_nxt;
  logic [LEN_W-1:0]   len_nxt;
  logic               err_nxt;

  djb2_step u_step (
    .hash_in  (hash_acc),
    .byte_in  (in_byte),
    .hash_out (hash_nxt)
  );

  assign accept = (state == HASH) && in_valid;

  // Length saturates at all-ones; the overflow is remembered in err.
  always_comb begin
    len_nxt = len_cnt;
    err_nxt = err_acc;
    if (&len_cnt) begin
      err_nxt = 1'b1;
    end else begin
      len_nxt = len_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hash_acc <= '0;
      exp_lat  <= '0;
      len_cnt  <= '0;
      err_acc  <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      match    <= 1'b0;
      hash_out <= '0;
      len_out  <= '0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            exp_lat  <= exp_hash;
            hash_acc <= DJB2_SEED;
            len_cnt  <= '0;
            err_acc  <= 1'b0;
            state    <= HASH;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        HASH: begin
          if (accept) begin
            hash_acc <= hash_nxt;
            len_cnt  <= len_nxt;
            err_acc  <= err_nxt;
            if (in_last) begin
              // Results are published from the same next-values that update the accumulators.
              state    <= DONE;
              done     <= 1'b1;
              in_ready <= 1'b0;
              hash_out <= hash_nxt;
              len_out  <= len_nxt;
              err      <= err_nxt;
              match    <= (hash_nxt == exp_lat);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_djb2_verify.sv
// Directed, table-driven bench for djb2_verify (default and LEN_W=4 instances share stimulus).
module tb_djb2_verify;

`ifdef DJB2_XOR_EN
  localparam logic [31:0] H_A  = 32'h0002B5C4;
  localparam logic [31:0] H_AB = 32'h00596E26;
  localparam logic [31:0] H_FF = 32'h0002B55A;
  localparam logic        M_A  = 1'b0;
`else
  localparam logic [31:0] H_A  = 32'h0002B606;
  localparam logic [31:0] H_AB = 32'h00597728;
  localparam logic [31:0] H_FF = 32'h0002B6A4;
  localparam logic        M_A  = 1'b1;
`endif
  localparam logic [31:0] H_00 = 32'h0002B5A5;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] exp_hash;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_last;

  logic        in_ready, busy, done, match, err;
  logic [31:0] hash_out;
  logic [15:0] len_out;
  logic        in_ready4, busy4, done4, match4, err4;
  logic [31:0] hash_out4;
  logic [3:0]  len_out4;

  int unsigned n_cmp;
  int unsigned n_fail;
  logic [7:0]  msg_buf [0:31];

  djb2_verify dut (
    .clk(clk), .rst(rst), .start(start), .exp_hash(exp_hash),
    .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .busy(busy), .done(done), .match(match),
    .hash_out(hash_out), .len_out(len_out), .err(err)
  );

  djb2_verify #(.LEN_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .exp_hash(exp_hash),
    .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready4), .busy(busy4), .done(done4), .match(match4),
    .hash_out(hash_out4), .len_out(len_out4), .err(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] exp_in;
    int unsigned n;
    logic [31:0] bytes;
    int unsigned gap;
    logic [31:0] want_hash;
    logic        want_match;
    logic [15:0] want_len;
  } vec_t;

  vec_t vt [5];

  function automatic logic [31:0] ref_step(input logic [31:0] h, input logic [7:0] b);
    logic [31:0] m;
    m = h * 32'd33;
`ifdef DJB2_XOR_EN
    return m ^ {24'd0, b};
`else
    return m + {24'd0, b};
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Sends msg_buf[0..n-1]; gap idle cycles precede every byte after the first.
  // poke pulses start (with a different exp_hash) mid-message and in DONE.
  task automatic run_msg(input logic [31:0] e, input int unsigned n,
                         input int unsigned gap, input bit poke);
    start    = 1'b1;
    exp_hash = e;
    tick();
    start    = 1'b0;
    exp_hash = 32'hDEAD_BEEF;
    chk("hash_in_ready", 32'(in_ready), 32'd1);
    chk("hash_busy", 32'(busy), 32'd1);
    for (int unsigned k = 0; k < n; k++) begin
      if (k > 0) begin
        for (int unsigned g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          in_last  = 1'b1;
          in_byte  = 8'hA5;
          start    = poke && (g == 0);
          exp_hash = 32'h0;
          tick();
          start    = 1'b0;
          chk("stall_done", 32'(done), 32'd0);
          chk("stall_ready", 32'(in_ready), 32'd1);
        end
      end
      in_valid = 1'b1;
      in_byte  = msg_buf[k];
      in_last  = (k == n - 1);
      tick();
      if (k != n - 1) chk("mid_done", 32'(done), 32'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    start    = poke;
    exp_hash = 32'h0;
    tick();
    start    = 1'b0;
    chk("post_done", 32'(done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd0);
  endtask

  initial begin
    logic [31:0] ref_h;
    n_cmp    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    exp_hash = '0;
    in_byte  = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;

    vt[0] = '{32'h0002B606, 1, 32'h00000061, 0, H_A,  M_A,  16'd1};
    vt[1] = '{32'h00000000, 2, 32'h00006261, 3, H_AB, 1'b0, 16'd2};
    vt[2] = '{H_AB,         2, 32'h00006261, 0, H_AB, 1'b1, 16'd2};
    vt[3] = '{H_00,         1, 32'h00000000, 1, H_00, 1'b1, 16'd1};
    vt[4] = '{32'hFFFFFFFF, 1, 32'h000000FF, 0, H_FF, 1'b0, 16'd1};

    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_hash", hash_out, 32'd0);
    chk("rst_len", 32'(len_out), 32'd0);
    chk("rst_len4", 32'(len_out4), 32'd0);
    tick();

    for (int i = 0; i < 5; i++) begin
      for (int unsigned k = 0; k < vt[i].n; k++) msg_buf[k] = vt[i].bytes[8*k +: 8];
      run_msg(vt[i].exp_in, vt[i].n, vt[i].gap, 1'b0);
      chk("vec_hash", hash_out, vt[i].want_hash);
      chk("vec_match", 32'(match), 32'(vt[i].want_match));
      chk("vec_len", 32'(len_out), 32'(vt[i].want_len));
      chk("vec_err", 32'(err), 32'd0);
    end

    // Abort mid-message with reset; rst must override start/in_valid/in_last.
    start    = 1'b1;
    exp_hash = H_A;
    tick();
    start    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_byte  = 8'h61 + 8'(k);
      in_last  = 1'b0;
      tick();
    end
    rst      = 1'b1;
    start    = 1'b1;
    in_valid = 1'b1;
    in_last  = 1'b1;
    tick();
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hash", hash_out, 32'd0);
    chk("abort_len", 32'(len_out), 32'd0);
    tick();
    chk("abort_done2", 32'(done), 32'd0);
    chk("abort_idle", 32'(in_ready), 32'd0);
    msg_buf[0] = 8'h61;
    run_msg(32'h0002B606, 1, 0, 1'b0);
    chk("after_abort_hash", hash_out, H_A);
    chk("after_abort_match", 32'(match), 32'(M_A));

    // start pulses in HASH and DONE must not re-latch exp_hash or restart.
    msg_buf[0] = 8'h61;
    msg_buf[1] = 8'h62;
    run_msg(H_AB, 2, 2, 1'b1);
    chk("poke_hash", hash_out, H_AB);
    chk("poke_match", 32'(match), 32'd1);
    tick();
    chk("poke_hold_hash", hash_out, H_AB);
    chk("poke_hold_busy", 32'(busy), 32'd0);

    // 17 bytes: LEN_W=4 saturates at 15 with err, hashing continues.
    ref_h = 32'd5381;
    for (int k = 0; k < 17; k++) begin
      msg_buf[k] = 8'(k * 13 + 5);
      ref_h = ref_step(ref_h, msg_buf[k]);
    end
    run_msg(ref_h, 17, 0, 1'b0);
    chk("long_hash", hash_out, ref_h);
    chk("long_len", 32'(len_out), 32'd17);
    chk("long_err", 32'(err), 32'd0);
    chk("long4_hash", hash_out4, ref_h);
    chk("long4_len", 32'(len_out4), 32'd15);
    chk("long4_err", 32'(err4), 32'd1);
    chk("long4_match", 32'(match4), 32'd1);

    // err is per message: a short message afterwards clears it.
    msg_buf[0] = 8'h61;
    run_msg(32'h0002B606, 1, 0, 1'b0);
    chk("clear4_err", 32'(err4), 32'd0);
    chk("clear4_len", 32'(len_out4), 32'd1);
    chk("clear4_hash", hash_out4, H_A);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
